// File: rtl/sys_bridge.sv
`default_nettype none
// ============================================================================
// Module   : sys_bridge
// Purpose  : CPU data-side bridge: DM / peripheral slots / IRQ regs, with
//            ready/timeout stalls for slow devices and maskable interrupts.
// Revision : 1.0
// ============================================================================
module sys_bridge #(
    parameter int          NUM_DEV    = 2,
    parameter logic [31:0] DM_LIMIT   = 32'h0000_3000,
    parameter logic [31:0] DEV_BASE   = 32'h0000_7f00,
    parameter logic [31:0] DEV_STRIDE = 32'h0000_0010,
    parameter logic [31:0] IRQ_BASE   = 32'h0000_7e00,
    parameter int          TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_req,
    input  logic [31:0]             cpu_addr,
    input  logic [3:0]              cpu_byteen,
    input  logic [31:0]             cpu_wdata,
    output logic [31:0]             cpu_rdata,
    output logic                    cpu_ready,
    output logic                    cpu_err,
    output logic [31:0]             dm_addr,
    output logic [3:0]              dm_byteen,
    output logic [31:0]             dm_wdata,
    input  logic [31:0]             dm_rdata,
    output logic [NUM_DEV-1:0]      dev_sel,
    output logic [1:0]              dev_addr,
    output logic                    dev_we,
    output logic [31:0]             dev_wdata,
    input  logic [32*NUM_DEV-1:0]   dev_rdata,
    input  logic [NUM_DEV-1:0]      dev_ready,
    input  logic [NUM_DEV-1:0]      dev_irq,
    output logic [5:0]              hwint
);

    localparam int c_CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEV_WAIT = 2'd1,
        S_RESP     = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_CW-1:0]     r_cnt;
    logic                r_err;
    logic [31:0]         r_rdata;
    logic [NUM_DEV-1:0]  r_dev_sel;
    logic                r_dev_we;
    logic [1:0]          r_dev_addr;
    logic                r_live;
    logic [NUM_DEV-1:0]  r_irq_q;
    logic [NUM_DEV-1:0]  r_pend;
    logic [NUM_DEV-1:0]  r_mask;

    logic [NUM_DEV-1:0]  w_hit_sel;
    logic                w_dm_hit;
    logic                w_pend_hit;
    logic                w_mask_hit;
    logic                w_dev_hit;
    logic                w_read;
    logic                w_full;
    logic                w_be_ok;
    logic                w_take;
    logic                w_pend_wr;
    logic                w_mask_wr;
    logic [NUM_DEV-1:0]  w_clr;
    logic [31:0]         w_slot_rdata;

    // Slot i owns words 0..2 at DEV_BASE + i*DEV_STRIDE; the fourth word is a hole.
    always_comb begin
        w_hit_sel = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (cpu_addr >= DEV_BASE + DEV_STRIDE * 32'(i) &&
                cpu_addr <  DEV_BASE + DEV_STRIDE * 32'(i) + 32'h0000_000C)
                w_hit_sel[i] = 1'b1;
        end
    end

    assign w_dm_hit   = cpu_addr < DM_LIMIT;
    assign w_pend_hit = !w_dm_hit && (cpu_addr == IRQ_BASE);
    assign w_mask_hit = !w_dm_hit && (cpu_addr == IRQ_BASE + 32'd4);
    assign w_dev_hit  = !w_dm_hit && !w_pend_hit && !w_mask_hit && (|w_hit_sel);

    assign w_read  = (cpu_byteen == 4'b0000);
    assign w_full  = (cpu_byteen == 4'b1111);
    assign w_be_ok = w_read || w_full;

    // r_live holds off every strobe from reset assertion until the first clock after release.
    assign w_take    = r_live && cpu_req && (r_state == S_IDLE);
    assign w_pend_wr = w_take && w_pend_hit && w_full;
    assign w_mask_wr = w_take && w_mask_hit && w_full;
    assign w_clr     = w_pend_wr ? cpu_wdata[NUM_DEV-1:0] : '0;

    always_comb begin
        w_slot_rdata = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (r_dev_sel[i])
                w_slot_rdata = dev_rdata[32*i +: 32];
        end
    end

    always_comb begin
        cpu_ready = 1'b0;
        cpu_err   = 1'b0;
        cpu_rdata = '0;
        dm_addr   = '0;
        dm_byteen = '0;
        if (r_state == S_RESP) begin
            cpu_ready = 1'b1;
            cpu_err   = r_err;
            cpu_rdata = r_rdata;
        end else if (w_take) begin
            if (w_dm_hit) begin
                cpu_ready = 1'b1;
                dm_addr   = cpu_addr;
                dm_byteen = cpu_byteen;
                cpu_rdata = dm_rdata;
            end else if (w_pend_hit || w_mask_hit) begin
                cpu_ready = 1'b1;
                cpu_err   = !w_be_ok;
                cpu_rdata = w_pend_hit ? 32'(r_pend) : 32'(r_mask);
            end else if (w_dev_hit) begin
                cpu_ready = !w_be_ok;
                cpu_err   = !w_be_ok;
            end else begin
                cpu_ready = 1'b1;
                cpu_err   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_dev_sel  <= '0;
            r_dev_we   <= 1'b0;
            r_dev_addr <= '0;
            r_live     <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_take && w_dev_hit && w_be_ok) begin
                        r_state    <= S_DEV_WAIT;
                        r_cnt      <= '0;
                        r_dev_sel  <= w_hit_sel;
                        r_dev_we   <= !w_read;
                        r_dev_addr <= cpu_addr[3:2];
                    end
                end
                S_DEV_WAIT: begin
                    if (|(dev_ready & r_dev_sel)) begin
                        r_state   <= S_RESP;
                        r_err     <= 1'b0;
                        r_rdata   <= r_dev_we ? 32'd0 : w_slot_rdata;
                        r_dev_sel <= '0;
                        r_dev_we  <= 1'b0;
                    end else if (r_cnt == c_CW'(TIMEOUT - 1)) begin
                        r_state   <= S_RESP;
                        r_err     <= 1'b1;
                        r_rdata   <= '0;
                        r_dev_sel <= '0;
                        r_dev_we  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A new rising edge is ORed in after the W1C mask, so set beats clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_q <= '0;
            r_pend  <= '0;
            r_mask  <= '1;
        end else begin
            r_irq_q <= dev_irq;
            r_pend  <= (r_pend & ~w_clr) | (dev_irq & ~r_irq_q);
            if (w_mask_wr)
                r_mask <= cpu_wdata[NUM_DEV-1:0];
        end
    end

    assign dm_wdata  = cpu_wdata;
    assign dev_wdata = cpu_wdata;
    assign dev_sel   = r_dev_sel;
    assign dev_we    = r_dev_we;
    assign dev_addr  = r_dev_addr;
    assign hwint     = 6'(r_pend & r_mask);

endmodule
`default_nettype wire
